// File: rtl/fft_mag_sq.sv
// Squared magnitude (re^2 + im^2) of a streaming FFT output, three register stages.
// Optional macro FFT_MAG_FRAME_CHECK_EN adds the fft_last frame-length check and frame_err.
module fft_mag_sq #(
    parameter int NSamples = 1024,
    parameter int DW       = 16,
    parameter int W        = 33,
    parameter int NBits    = $clog2(NSamples)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] fft_real,
    input  logic [DW-1:0] fft_imag,
    input  logic          fft_valid,
    input  logic          fft_last,
    output logic          fft_ready,
    output logic [W-1:0]  mag,
    output logic          mag_valid,
    output logic          mag_last,
    input  logic          mag_ready,
    output logic          frame_err
);

    localparam logic [NBits-1:0] LAST_IDX = NBits'(NSamples - 1);

    // Handshake: a beat transfers on a rising edge where valid && ready. The whole
    // pipeline moves only when the output register is empty or being drained, and
    // fft_ready is that same advance term, so no beat is ever dropped or buffered.
    logic adv;
    logic fire;
    logic at_last;
    logic [NBits-1:0] idx;
    logic [NBits-1:0] idx_next;

    logic          s1_valid;
    logic          s1_last;
    logic [DW-1:0] s1_re;
    logic [DW-1:0] s1_im;

    logic            s2_valid;
    logic            s2_last;
    logic [2*DW-1:0] s2_re2;
    logic [2*DW-1:0] s2_im2;

    logic [2*DW-1:0] re_sq;
    logic [2*DW-1:0] im_sq;

    assign adv       = !(mag_valid && !mag_ready);
    assign fft_ready = adv;
    assign fire      = fft_valid && adv;
    assign at_last   = (idx == LAST_IDX);

    // Sign-extend to 2*DW before multiplying; the square is never negative and
    // at most 2^(2*DW-2), so the low 2*DW bits are the exact unsigned value.
    assign re_sq = {{DW{s1_re[DW-1]}}, s1_re} * {{DW{s1_re[DW-1]}}, s1_re};
    assign im_sq = {{DW{s1_im[DW-1]}}, s1_im} * {{DW{s1_im[DW-1]}}, s1_im};

    always_comb begin
        idx_next = at_last ? '0 : idx + 1'b1;
`ifdef FFT_MAG_FRAME_CHECK_EN
        if (fft_last) idx_next = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (fire) begin
            idx <= idx_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_re2    <= '0;
            s2_im2    <= '0;
            mag       <= '0;
            mag_valid <= 1'b0;
            mag_last  <= 1'b0;
        end else if (adv) begin
            s1_valid  <= fire;
            s1_last   <= at_last;
            s1_re     <= fft_real;
            s1_im     <= fft_imag;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_re2    <= re_sq;
            s2_im2    <= im_sq;
            mag_valid <= s2_valid;
            mag_last  <= s2_valid && s2_last;
            mag       <= {{(W-2*DW){1'b0}}, s2_re2} + {{(W-2*DW){1'b0}}, s2_im2};
        end
    end

`ifdef FFT_MAG_FRAME_CHECK_EN
    // Pulses in the cycle the offending beat sits in S1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= fire && (fft_last != at_last);
        end
    end
`else
    logic unused_last;
    assign unused_last = fft_last;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fft_mag_sq.sv
// Directed bench for fft_mag_sq: vector table, latency, streaming, stall, reset and frame-check sequences.
module tb_fft_mag_sq;

    localparam int N  = 1024;
    localparam int DW = 16;
    localparam int W  = 33;

    logic          clk;
    logic          reset;
    logic [DW-1:0] fft_real;
    logic [DW-1:0] fft_imag;
    logic          fft_valid;
    logic          fft_last;
    logic          fft_ready;
    logic [W-1:0]  mag;
    logic          mag_valid;
    logic          mag_last;
    logic          mag_ready;
    logic          frame_err;

    fft_mag_sq #(.NSamples(N), .DW(DW), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .fft_real  (fft_real),
        .fft_imag  (fft_imag),
        .fft_valid (fft_valid),
        .fft_last  (fft_last),
        .fft_ready (fft_ready),
        .mag       (mag),
        .mag_valid (mag_valid),
        .mag_last  (mag_last),
        .mag_ready (mag_ready),
        .frame_err (frame_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    int exp_idx = 0;
    int exp_err_cnt = 0;
    int err_cnt = 0;

    int cyc = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;
    int last_cnt = 0;

    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_mag;
    logic         prev_last;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [W-1:0]  exp_mag;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_mag(input logic [DW-1:0] re, input logic [DW-1:0] im);
        longint a;
        longint b;
        a = longint'($signed(re));
        b = longint'($signed(im));
        return W'(a * a + b * b);
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (reset && hold_prev) begin
            check("hold_valid", {63'd0, mag_valid}, 64'd1);
            check("hold_mag", {31'd0, mag}, {31'd0, prev_mag});
            check("hold_last", {63'd0, mag_last}, {63'd0, prev_last});
        end
        if (reset && mag_valid && mag_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got beat mag=%0d expected none", mag);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_mag", {31'd0, mag}, {31'd0, e[W-1:0]});
                check("sb_last", {63'd0, mag_last}, {63'd0, e[W]});
            end
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
            if (mag_last) last_cnt++;
        end
        if (reset && frame_err) err_cnt++;
        hold_prev = reset && mag_valid && !mag_ready;
        prev_mag  = mag;
        prev_last = mag_last;
    end

    // driver tasks
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic last_in, input logic [W-1:0] exp_mag);
        logic got;
        logic el;
        fft_real  = re;
        fft_imag  = im;
        fft_last  = last_in;
        fft_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (fft_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got fft_ready=0 for 100 cycles expected 1");
        end
        el = (exp_idx == N - 1);
        exp_q.push_back({el, exp_mag});
`ifdef FFT_MAG_FRAME_CHECK_EN
        if (last_in != el) exp_err_cnt++;
        exp_idx = (last_in || el) ? 0 : exp_idx + 1;
`else
        exp_idx = el ? 0 : exp_idx + 1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input int last_beat);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] re;
            logic [DW-1:0] im;
            logic          l;
            re = DW'($urandom_range(0, 65535));
            im = DW'($urandom_range(0, 65535));
            l  = (k == last_beat) || (last_beat < 0 && exp_idx == N - 1);
            send(re, im, l, model_mag(re, im));
        end
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // called at posedge+#1: reset takes effect at once, then released after two edges
    task automatic apply_reset();
        reset     = 1'b0;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        #1;
        check("rst_mag_valid", {63'd0, mag_valid}, 64'd0);
        check("rst_mag", {31'd0, mag}, 64'd0);
        check("rst_mag_last", {63'd0, mag_last}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_fft_ready", {63'd0, fft_ready}, 64'd1);
        exp_q.delete();
        exp_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_rst_fft_ready", {63'd0, fft_ready}, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        apply_reset();
    endtask

    initial begin
        vecs[0] = '{re: 16'sd3,      im: -16'sd4,     exp_mag: 33'd25};
        vecs[1] = '{re: -16'sd32768, im: -16'sd32768, exp_mag: 33'd2147483648};
        vecs[2] = '{re: 16'sd32767,  im: 16'sd32767,  exp_mag: 33'd2147352578};
        vecs[3] = '{re: -16'sd32768, im: 16'sd32767,  exp_mag: 33'd2147418113};
        vecs[4] = '{re: 16'sd0,      im: 16'sd0,      exp_mag: 33'd0};
        vecs[5] = '{re: -16'sd1,     im: 16'sd1,      exp_mag: 33'd2};
        vecs[6] = '{re: 16'sd100,    im: -16'sd200,   exp_mag: 33'd50000};
        vecs[7] = '{re: 16'sd12345,  im: -16'sd6789,  exp_mag: 33'd198489546};

        reset     = 1'b1;
        fft_real  = '0;
        fft_imag  = '0;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        mag_ready = 1'b1;
        #2;
        apply_reset();

        // single beat latency: valid exactly three cycles after acceptance
        send(16'sd3, -16'sd4, 1'b0, 33'd25);
        fft_valid = 1'b0;
        @(negedge clk);
        check("lat_c1_valid", {63'd0, mag_valid}, 64'd0);
        @(negedge clk);
        check("lat_c2_valid", {63'd0, mag_valid}, 64'd0);
        @(negedge clk);
        check("lat_c3_valid", {63'd0, mag_valid}, 64'd1);
        check("lat_c3_mag", {31'd0, mag}, 64'd25);
        drain();

        // vector table, back to back
        for (int i = 0; i < 8; i++) send(vecs[i].re, vecs[i].im, 1'b0, vecs[i].exp_mag);
        fft_valid = 1'b0;
        drain();

        // two full frames with no gaps, one mag_last per frame
        do_reset();
        pop_cnt  = 0;
        last_cnt = 0;
        stream(2 * N, -1);
        drain();
        check("frames_beats", 64'(pop_cnt), 64'(2 * N));
        check("frames_no_gaps", 64'(last_pop - first_pop), 64'(2 * N - 1));
        check("frames_last_cnt", 64'(last_cnt), 64'd2);

        // five-cycle downstream stall mid-stream
        fork
            stream(40, -1);
            begin
                repeat (10) @(posedge clk);
                #1;
                mag_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("stall_fft_ready", {63'd0, fft_ready}, 64'd0);
                end
                @(posedge clk);
                #1;
                mag_ready = 1'b1;
            end
        join
        drain();

        // reset with beats in flight, then a clean frame
        do_reset();
        stream(500, -1);
        @(posedge clk);
        #1;
        apply_reset();
        pop_cnt  = 0;
        last_cnt = 0;
        stream(N, -1);
        drain();
        check("rst_frame_beats", 64'(pop_cnt), 64'(N));
        check("rst_frame_last_cnt", 64'(last_cnt), 64'd1);

        // early fft_last on beat 100
        do_reset();
        err_cnt     = 0;
        exp_err_cnt = 0;
        stream(1200, 100);
        drain();
        check("frame_err_count", 64'(err_cnt), 64'(exp_err_cnt));
`ifdef FFT_MAG_FRAME_CHECK_EN
        check("frame_err_expected", 64'(exp_err_cnt), 64'd2);
`else
        check("frame_err_expected", 64'(exp_err_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_mag_sq.md
FFT_MAG_SQ -- requirements
Module: fft_mag_sq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NSamples, 1024, FFT points per frame.
- DW, 16, signed width of each FFT real/imag component.
- W, 33, magnitude output width; must be >= 2*DW+1.
- NBits, $clog2(NSamples), sample-index width.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fft_real  in  DW  signed real part of the FFT bin.
- fft_imag  in  DW  signed imaginary part of the FFT bin.
- fft_valid  in  1  input beat valid.
- fft_last  in  1  upstream end-of-frame marker.
- fft_ready  out  1  input beat accepted when fft_valid && fft_ready.
- mag  out  W  re^2+im^2, unsigned, zero-extended.
- mag_valid  out  1  output beat valid.
- mag_last  out  1  qualifies the beat of sample index NSamples-1.
- mag_ready  in  1  downstream accept; tie high for fft_find_peak.
- frame_err  out  1  one-cycle pulse on a frame-length mismatch.

Function
REQ-003 Pipeline SHALL have three stages: S1 registers re/im, S2 registers re*re and im*im as 2*DW-bit unsigned, S3 registers the sum into mag.
REQ-004 Pipeline advance SHALL be adv = !(mag_valid && !mag_ready); all stages and valid bits SHALL hold when adv=0.
REQ-005 fft_ready SHALL equal adv, combinationally, with no registered skid.
REQ-006 With mag_ready held high, mag SHALL appear exactly 3 cycles after acceptance, at one beat per cycle.
REQ-007 Bubbles SHALL propagate: a stage with valid=0 SHALL still advance when adv=1.
REQ-008 The sample counter i (NBits) SHALL increment on each accepted beat and wrap NSamples-1 -> 0.
REQ-009 mag_last SHALL be derived from the counter value travelling with the beat (i==NSamples-1), not from fft_last.
REQ-010 Arithmetic SHALL be exact for all inputs: (-2^(DW-1))^2 + (-2^(DW-1))^2 = 2^(2DW-1) with no overflow or saturation.
REQ-011 mag, mag_valid and mag_last SHALL hold stable while mag_valid=1 and mag_ready=0.

Reset
REQ-012 On reset low, all pipeline data and valid bits, i, mag, mag_valid, mag_last and frame_err SHALL go to 0 asynchronously.
REQ-013 fft_ready SHALL read 1 during and after reset, since the pipeline is empty.
REQ-014 Reset mid-frame SHALL discard all in-flight beats; the first beat accepted after release SHALL be index 0.

Configuration
REQ-015 With macro FFT_MAG_FRAME_CHECK_EN defined:
- A mismatch is an accepted beat where fft_last != (i==NSamples-1).
- On a mismatch, frame_err SHALL pulse 1 for one cycle, coincident with the beat entering S1.
- If fft_last=1 early, i SHALL resync to 0 for the next beat.
- If fft_last is missing, i SHALL wrap normally.
REQ-016 Without FFT_MAG_FRAME_CHECK_EN:
- fft_last SHALL be ignored.
- frame_err SHALL be constant 0.
- No check logic SHALL be synthesised.

Verification
REQ-017 re=3, im=-4, single beat, mag_ready=1 -> mag=25, mag_valid high exactly 3 cycles after acceptance, mag_last=0.
REQ-018 re=-32768, im=-32768 -> mag=2147483648 (2^31), bit 32 = 0.
REQ-019 1024 back-to-back beats, mag_ready=1 -> 1024 mag_valid cycles with no gaps; mag_last only on the 1024th; second frame restarts at index 0.
REQ-020 mag_ready low for 5 cycles mid-stream -> fft_ready low in those cycles, mag held stable, no beat lost or duplicated (compare against a golden list).
REQ-021 Reset asserted after 500 beats with 2 in flight -> mag_valid=0 immediately; the next frame's mag_last lands on its 1024th beat.
REQ-022 With FFT_MAG_FRAME_CHECK_EN, fft_last on beat 100 -> single frame_err pulse, and beat 101 treated as index 0. Without the macro -> frame_err stays 0 and index continues.
